// File: rtl/viterbi_soft_decoder.sv
// viterbi_soft_decoder
// Rate-1/2 soft-decision Viterbi decoder with register-exchange survivors.
// One symbol pair is accepted per in_valid. Once DEPTH pairs of the frame have
// been accepted, each accepted pair yields one decoded bit two clocks later.
//
// Optional build macro:
//   VITERBI_BEST_STATE_EN - take d_out from the survivor of the state with the
//                           smallest path metric (lowest index on ties).
//                           Without it, state 0's survivor is used and no
//                           comparator tree is built.
module viterbi_soft_decoder #(
    parameter int           K     = 4,
    parameter int           SW    = 3,
    parameter int           MW    = 8,
    parameter int           DEPTH = 32,
    parameter logic [K-1:0] G0    = 4'b1101,
    parameter logic [K-1:0] G1    = 4'b1111
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [SW-1:0] sym_0,
    input  logic [SW-1:0] sym_1,
    input  logic          frame_start,
    output logic          out_valid,
    output logic          d_out
);

    localparam int S  = 1 << (K - 1);
    localparam int SB = K - 1;
    localparam int FW = $clog2(DEPTH + 1);

    localparam logic [SW-1:0] SYM_MAX   = '1;
    localparam logic [MW-1:0] PM_INIT   = {2'b00, 1'b1, {(MW - 3){1'b0}}};
    localparam logic [FW-1:0] FILL_FULL = FW'(DEPTH);
    localparam logic [FW-1:0] FILL_LAST = FW'(DEPTH - 1);

    // Distance of a soft symbol from an expected code bit.
    function automatic logic [SW:0] sym_dist(input logic [SW-1:0] x, input logic c);
        return c ? {1'b0, SYM_MAX - x} : {1'b0, x};
    endfunction

    // Branch metric for the K-bit path {u, s}; the newest input bit is the MSB.
    function automatic logic [SW:0] branch_metric(input logic [SW-1:0] s0,
                                                  input logic [SW-1:0] s1,
                                                  input logic [K-1:0]  path);
        return sym_dist(s0, ^(path & G0)) + sym_dist(s1, ^(path & G1));
    endfunction

    // Start-of-frame metric: the encoder is known to start in state 0.
    function automatic logic [MW-1:0] init_metric(input int s);
        return (s == 0) ? '0 : PM_INIT;
    endfunction

    logic [MW-1:0]    pm       [S];
    logic [DEPTH-1:0] surv     [S];
    logic [FW-1:0]    fill;
    logic             vld_p0;

    logic [MW-1:0]    src_pm   [S];
    logic [DEPTH-2:0] src_keep [S];
    logic [FW-1:0]    src_fill;
    logic [S-1:0]     msb_vec;
    logic             all_msb;
    logic [MW-1:0]    nxt_pm   [S];
    logic [DEPTH-1:0] nxt_surv [S];
    logic [SB-1:0]    sel;

    // A pair arriving with frame_start is decoded against a freshly started frame.
    assign src_fill = frame_start ? '0 : fill;

    for (genvar s = 0; s < S; s++) begin : g_src
        assign src_pm[s]   = frame_start ? init_metric(s) : pm[s];
        assign src_keep[s] = frame_start ? '0 : surv[s][DEPTH-2:0];
        // Initial metrics never carry the MSB, so a restart never normalises.
        assign msb_vec[s]  = ~frame_start & pm[s][MW-1];
    end

    assign all_msb = &msb_vec;

    for (genvar ns = 0; ns < S; ns++) begin : g_acs
        localparam logic [SB-1:0] ST    = SB'(ns);
        localparam logic [SB-1:0] PRED0 = {ST[SB-2:0], 1'b0};
        localparam logic [SB-1:0] PRED1 = {ST[SB-2:0], 1'b1};

        logic [MW-1:0] cand0;
        logic [MW-1:0] cand1;
        logic [MW-1:0] win;
        logic          dec;

        // The transition path {u, pred} equals {ns, lost bit}.
        assign cand0 = src_pm[PRED0] + MW'(branch_metric(sym_0, sym_1, {ST, 1'b0}));
        assign cand1 = src_pm[PRED1] + MW'(branch_metric(sym_0, sym_1, {ST, 1'b1}));
        // Strict compare: a tie keeps predecessor 0.
        assign dec   = (cand1 < cand0);
        assign win   = dec ? cand1 : cand0;

        assign nxt_pm[ns]   = all_msb ? {1'b0, win[MW-2:0]} : win;
        assign nxt_surv[ns] = {dec ? src_keep[PRED1] : src_keep[PRED0], ST[SB-1]};
    end

`ifdef VITERBI_BEST_STATE_EN
    // Heap-ordered comparator tree; leaf S+s is state s, so the left child
    // always covers lower state indices and wins on equal metrics.
    function automatic logic [SB-1:0] best_state(input logic [MW-1:0] m [S]);
        logic [MW-1:0] tp [1:2*S-1];
        logic [SB-1:0] ti [1:2*S-1];
        for (int s = 0; s < S; s++) begin
            tp[S + s] = m[s];
            ti[S + s] = SB'(s);
        end
        for (int n = S - 1; n >= 1; n--) begin
            if (tp[2*n + 1] < tp[2*n]) begin
                tp[n] = tp[2*n + 1];
                ti[n] = ti[2*n + 1];
            end else begin
                tp[n] = tp[2*n];
                ti[n] = ti[2*n];
            end
        end
        return ti[1];
    endfunction

    assign sel = best_state(pm);
`else
    assign sel = '0;
`endif

    // Accepted pairs advance metrics, survivors and fill; a lone frame_start restarts the frame.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int s = 0; s < S; s++) begin
                pm[s]   <= init_metric(s);
                surv[s] <= '0;
            end
            fill   <= '0;
            vld_p0 <= 1'b0;
        end else if (in_valid) begin
            for (int s = 0; s < S; s++) begin
                pm[s]   <= nxt_pm[s];
                surv[s] <= nxt_surv[s];
            end
            fill   <= (src_fill == FILL_FULL) ? src_fill : src_fill + FW'(1);
            vld_p0 <= (src_fill >= FILL_LAST);
        end else if (frame_start) begin
            for (int s = 0; s < S; s++) begin
                pm[s]   <= init_metric(s);
                surv[s] <= '0;
            end
            fill   <= '0;
            vld_p0 <= 1'b0;
        end else begin
            vld_p0 <= 1'b0;
        end
    end

    // Output register: oldest survivor bit one clock after acceptance; a restart drops it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            out_valid <= 1'b0;
            d_out     <= 1'b0;
        end else begin
            out_valid <= vld_p0 & ~frame_start;
            if (vld_p0) begin
                d_out <= surv[sel][DEPTH-1];
            end
        end
    end

endmodule

// File: doc/viterbi_soft_decoder.md
# viterbi_soft_decoder

Parametrised rate-1/2 Viterbi decoder that succeeds the fixed 8-state hard-decision decoder. Constraint length, soft-symbol width, metric width and survivor depth are parameters. Survivor paths use register exchange instead of banked trellis memories plus traceback. The block sits between the channel demapper and the bit sink, takes one soft symbol pair per `in_valid`, and emits one decoded bit per accepted pair once the survivor pipeline is full.

## Interface
- `K`, 4: constraint length. Number of states S = 2^(K-1). Legal range 3..7.
- `SW`, 3: soft-symbol width. SW=1 gives hard decision.
- `MW`, 8: path-metric width. Must satisfy MW ≥ SW+K+1.
- `DEPTH`, 32: survivor register length in bits. Must be ≥ 5·K.
- `G0`, 4'b1101: generator polynomial for `sym_0`. K bits; bit K-1 taps the newest input bit.
- `G1`, 4'b1111: generator polynomial for `sym_1`.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  reset, synchronous, active-low.
- `in_valid`  in  1  symbol pair present. There is no backpressure; the block is always ready.
- `sym_0`  in  SW  soft symbol for G0. Offset-binary: 0 = strong '0', 2^SW-1 = strong '1'.
- `sym_1`  in  SW  soft symbol for G1, same encoding.
- `frame_start`  in  1  one-cycle pulse that starts a new frame.
- `out_valid`  out  1  `d_out` is valid this cycle.
- `d_out`  out  1  decoded bit.

## Operation
- State numbering: state s holds the last K-1 input bits, newest in the MSB.
- State transition: input u moves state s to ns = {u, s[K-2:1]}.
- Predecessors of ns: p0 = {ns[K-3:0], 0} and p1 = {ns[K-3:0], 1}.
- Expected code bits: ci = ^({u,s} & Gi).
- Branch metric is SW+1 bits: BM = d(sym_0,c0) + d(sym_1,c1).
  - d(x,0) = x.
  - d(x,1) = (2^SW-1) - x.
- ACS per state:
  - Candidates: PM[p0]+BM0 and PM[p1]+BM1.
  - The smaller candidate wins.
  - On a tie, p0 wins (decision 0).
- Normalisation: if every current PM has its MSB set, every new PM is written with its MSB cleared. Under the MW constraint, no metric overflows.
- Metric initialisation on reset or `frame_start`: PM[0] = 0; every other state = 2^(MW-3).
- Survivor update: surv_new[ns] = {surv[winning pred][DEPTH-2:0], ns[K-2]}. The newest bit enters at the LSB.
- Output bit: surv[sel][DEPTH-1]. The choice of `sel` is set under Configuration.
- Fill counter: saturates at DEPTH and counts accepted pairs since the frame started. Output is produced only once fill = DEPTH.
- Every accepted pair after the fill produces exactly one output bit. Output bit number m-DEPTH+1 of the frame leaves when pair m (0-based) is accepted.
- `frame_start` and `in_valid` in the same cycle: the pair is processed against the initial metrics and zeroed survivors, and counts as fill = 1. Any pending output from the old frame is discarded.
- `frame_start` alone: re-initialises metrics, clears survivors and the fill counter, and discards any pending output.

## Timing
- Reset: synchronous, active-low, sampled at the rising edge of `clk`. After the first edge with `rst`=0:
  - `out_valid` = 0 and `d_out` = 0.
  - Fill = 0.
  - Survivors = 0.
  - Metrics take their initial values.
- Reset asserted mid-frame aborts the frame with no further outputs.
- Acceptance: `in_valid` sampled high at edge E updates PM and survivors at E.
- Output register: loaded at E+1 from the updated survivors. `out_valid` and `d_out` are valid for the one cycle following E+1.
- Latency: 2 clocks from acceptance to output.
- Back-to-back `in_valid`: full throughput, one output per cycle.
- Gaps in `in_valid`: `out_valid` stays low, and all metric and survivor state holds.

## Configuration
- `VITERBI_BEST_STATE_EN` defined:
  - At E+1, a comparator tree finds the state with minimum PM; ties go to the lowest index.
  - `d_out` comes from that state's survivor MSB.
  - Latency is unchanged.
- `VITERBI_BEST_STATE_EN` undefined:
  - `sel` = 0 and no comparator tree is built.
  - Correct decoding relies on DEPTH being large enough for the survivors to merge.

## Test plan
- **Reset:** hold `rst`=0 for 3 clocks with `in_valid`=1 → `out_valid`=0 and `d_out`=0 throughout, and again on the first cycle after release.
- **Fill and latency, K=4, DEPTH=32:** 40 back-to-back pairs of (0,0) → first `out_valid` 2 clocks after the 32nd pair is accepted; exactly 9 outputs, all 0.
- **Clean decode:** repeat the pattern 1011_0010 for 256 bits, encoded with G0=1101 and G1=1111 and mapped to ideal symbols 0/7 → `d_out` stream equals the input with no errors, shifted by 31 accepted pairs.
- **Error correction:** same stream, invert one symbol (7↔0) every 20 pairs → zero output bit errors. Repeat with and without `VITERBI_BEST_STATE_EN`.
- **Gaps and normalisation:** drive `in_valid` with a random 50% duty over 2000 noisy pairs (random ±2 perturbation) → output sequence identical to the gap-free run; outputs = accepted-31; the bench monitors that no PM wraps and that MSB-clear events occur.
- **Frame restart:** pulse `frame_start` together with `in_valid` at pair 100 → no outputs until 31 more pairs after the coincident one; first post-restart output equals bit 0 of the new frame.
